// File: rtl/game_status_tracker_if.sv
// Status bundle between the game state controller / HUD side and the outcome tracker.
// Latency: pure wiring, no storage.
// Backpressure: none; phase levels and hit pulses are sampled every cycle.
interface game_status_tracker_if;
    logic        start;
    logic        play;
    logic        gameover;
    logic        enemy_hit;
    logic        ship_hit;
    logic        done;
    logic        win;
    logic [1:0]  lives;
    logic [5:0]  enemies_left;
    logic [15:0] score;
    logic        invuln;

    // Controller / HUD side: drives phase and hit events, consumes status.
    modport master (
        output start, play, gameover, enemy_hit, ship_hit,
        input  done, win, lives, enemies_left, score, invuln
    );

    // Tracker side.
    modport slave (
        input  start, play, gameover, enemy_hit, ship_hit,
        output done, win, lives, enemies_left, score, invuln
    );
endinterface

// File: rtl/game_status_tracker.sv
// Per-game outcome tracker: lives, enemies remaining, saturating BCD score, respawn invulnerability.
// Latency: all outputs registered; hit effects show next cycle, done/win one cycle after a terminal count.
// Backpressure: none; hits are consumed or ignored in the cycle they arrive. Define BONUS_LIFE_EN for a one-off extra life at 1000 points.
module game_status_tracker #(
    parameter int NUM_ENEMIES      = 40,
    parameter int NUM_LIVES        = 3,
    parameter int RESPAWN_CYCLES   = 100000000,
    parameter int POINTS_PER_ENEMY = 50
) (
    input  logic                 Clk,
    input  logic                 Reset,
    game_status_tracker_if.slave gs
);
    localparam int              CW           = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LOAD     = CW'(RESPAWN_CYCLES - 1);
    localparam logic [1:0]      LIVES_INIT   = 2'(NUM_LIVES);
    localparam logic [5:0]      ENEMIES_INIT = 6'(NUM_ENEMIES);
    // Kill reward converted once from decimal to packed BCD.
    localparam logic [15:0]     PTS_BCD      = {4'((POINTS_PER_ENEMY / 1000) % 10),
                                                4'((POINTS_PER_ENEMY / 100) % 10),
                                                4'((POINTS_PER_ENEMY / 10) % 10),
                                                4'(POINTS_PER_ENEMY % 10)};

    typedef enum logic [1:0] {IDLE, ACTIVE, RESPAWN, FINISHED} state_t;

    state_t        state_q, state_d;
    logic          done_q, done_d;
    logic          win_q, win_d;
    logic          invuln_q, invuln_d;
    logic [1:0]    lives_q, lives_d;
    logic [5:0]    enemies_q, enemies_d;
    logic [15:0]   score_q, score_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef BONUS_LIFE_EN
    logic          bonus_q, bonus_d;
`endif

    logic          enemy_take;
    logic          ship_take;
    logic [2:0]    lives_n;
    logic [16:0]   add_res;
    logic [15:0]   score_sum;

    // Four-digit BCD add; bit 16 is the carry out of the thousands digit.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  dsum;
        logic        c;
        logic [15:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            dsum = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, c};
            if (dsum > 5'd9) begin
                dsum = dsum + 5'd6;
                c    = 1'b1;
            end else begin
                c    = 1'b0;
            end
            r[i*4 +: 4] = dsum[3:0];
        end
        return {c, r};
    endfunction

    assign add_res   = bcd_add(score_q, PTS_BCD);
    assign score_sum = add_res[16] ? 16'h9999 : add_res[15:0];

    // Next-state: game phase, counters and score for the coming cycle.
    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        win_d      = win_q;
        invuln_d   = invuln_q;
        lives_d    = lives_q;
        enemies_d  = enemies_q;
        score_d    = score_q;
        cnt_d      = cnt_q;
`ifdef BONUS_LIFE_EN
        bonus_d    = bonus_q;
`endif
        enemy_take = 1'b0;
        ship_take  = 1'b0;
        lives_n    = {1'b0, lives_q};
        case (state_q)
            IDLE: begin
                if (gs.start) begin
                    lives_d   = LIVES_INIT;
                    enemies_d = ENEMIES_INIT;
                    score_d   = 16'h0000;
                    done_d    = 1'b0;
                    win_d     = 1'b0;
`ifdef BONUS_LIFE_EN
                    bonus_d   = 1'b0;
`endif
                end
                if (gs.play) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE, RESPAWN: begin
                if (!gs.play) begin
                    // Controller aborted the game: park, keep counters until the next start.
                    state_d  = IDLE;
                    invuln_d = 1'b0;
                    cnt_d    = '0;
                end else if (enemies_q == 6'd0 || lives_q == 2'd0) begin
                    // Terminal counts seen last cycle; a cleared wave beats an empty life count.
                    state_d  = FINISHED;
                    done_d   = 1'b1;
                    win_d    = (enemies_q == 6'd0);
                    invuln_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    enemy_take = gs.enemy_hit;
                    // The last enemy falling wins the game, so a coincident ship hit is dropped.
                    ship_take  = gs.ship_hit && (state_q == ACTIVE) &&
                                 !(gs.enemy_hit && enemies_q == 6'd1);
                    if (enemy_take) begin
                        enemies_d = enemies_q - 6'd1;
                        score_d   = score_sum;
                    end
                    if (ship_take) begin
                        lives_n = lives_n - 3'd1;
                    end
`ifdef BONUS_LIFE_EN
                    if (enemy_take && !bonus_q && score_q[15:12] == 4'd0 && score_sum[15:12] != 4'd0) begin
                        bonus_d = 1'b1;
                        if (lives_n < 3'd3) begin
                            lives_n = lives_n + 3'd1;
                        end
                    end
                    lives_d = lives_n[1:0];
`else
                    lives_d = lives_n[1:0];
`endif
                    if (state_q == RESPAWN) begin
                        if (cnt_q == '0) begin
                            state_d  = ACTIVE;
                            invuln_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                    if (ship_take && lives_n != 3'd0) begin
                        state_d  = RESPAWN;
                        cnt_d    = CNT_LOAD;
                        invuln_d = 1'b1;
                    end
                end
            end
            FINISHED: begin
                if (gs.start) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    win_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset clears everything to the power-on game setup.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
            invuln_q  <= 1'b0;
            lives_q   <= LIVES_INIT;
            enemies_q <= ENEMIES_INIT;
            score_q   <= 16'h0000;
            cnt_q     <= '0;
`ifdef BONUS_LIFE_EN
            bonus_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            win_q     <= win_d;
            invuln_q  <= invuln_d;
            lives_q   <= lives_d;
            enemies_q <= enemies_d;
            score_q   <= score_d;
            cnt_q     <= cnt_d;
`ifdef BONUS_LIFE_EN
            bonus_q   <= bonus_d;
`endif
        end
    end

    assign gs.done         = done_q;
    assign gs.win          = win_q;
    assign gs.invuln       = invuln_q;
    assign gs.lives        = lives_q;
    assign gs.enemies_left = enemies_q;
    assign gs.score        = score_q;

    // The controller may only enter GAMEOVER once this block reports done.
    gameover_needs_done: assert property (@(posedge Clk) disable iff (!Reset) $rose(gs.gameover) |-> gs.done);

endmodule

// File: tb/tb_game_status_tracker.sv
// Bench for game_status_tracker: two parameterisations driven with identical phase/hit stimulus.
// Expected status is computed per cycle by a decimal-arithmetic game model and queued.
// A monitor pops one expectation per clock edge (and on reset assertion) and compares.
module tb_game_status_tracker;
    localparam int A_NE = 40, A_NL = 3, A_RC = 16, A_PT = 50;
    localparam int B_NE = 63, B_NL = 2, B_RC = 5,  B_PT = 260;

    typedef struct {
        int lives;
        int enemies;
        int score;      // plain decimal points
        int resp_left;  // invulnerable cycles still to run
        bit playing;
        bit fin;
        bit done;
        bit win;
        bit bonus;
    } mdl_t;

    typedef struct packed {
        logic        done;
        logic        win;
        logic        invuln;
        logic [1:0]  lives;
        logic [5:0]  enemies;
        logic [15:0] score;
    } exp_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    game_status_tracker_if ifa();
    game_status_tracker_if ifb();

    game_status_tracker #(.NUM_ENEMIES(A_NE), .NUM_LIVES(A_NL), .RESPAWN_CYCLES(A_RC), .POINTS_PER_ENEMY(A_PT))
        u_a (.Clk(Clk), .Reset(Reset), .gs(ifa));
    game_status_tracker #(.NUM_ENEMIES(B_NE), .NUM_LIVES(B_NL), .RESPAWN_CYCLES(B_RC), .POINTS_PER_ENEMY(B_PT))
        u_b (.Clk(Clk), .Reset(Reset), .gs(ifb));

    int ne_p[2] = '{A_NE, B_NE};
    int nl_p[2] = '{A_NL, B_NL};
    int rc_p[2] = '{A_RC, B_RC};
    int pt_p[2] = '{A_PT, B_PT};

    mdl_t m[2];
    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic exp_t expect_of(mdl_t s);
        exp_t e;
        e.done    = s.done;
        e.win     = s.win;
        e.invuln  = (s.resp_left > 0);
        e.lives   = 2'(s.lives);
        e.enemies = 6'(s.enemies);
        e.score   = to_bcd(s.score);
        return e;
    endfunction

    // Game rules for one clock edge, parameter set k.
    function automatic mdl_t step(mdl_t s, int k, bit r, bit st, bit pl, bit eh, bit sh);
        if (!r) begin
            s.lives = nl_p[k]; s.enemies = ne_p[k]; s.score = 0; s.resp_left = 0;
            s.playing = 0; s.fin = 0; s.done = 0; s.win = 0; s.bonus = 0;
        end else if (s.fin) begin
            if (st) begin s.fin = 0; s.done = 0; s.win = 0; end
        end else if (!s.playing) begin
            if (st) begin
                s.lives = nl_p[k]; s.enemies = ne_p[k]; s.score = 0;
                s.done = 0; s.win = 0; s.bonus = 0;
            end
            if (pl) s.playing = 1;
        end else if (!pl) begin
            s.playing = 0; s.resp_left = 0;
        end else if (s.enemies == 0 || s.lives == 0) begin
            s.playing = 0; s.fin = 1; s.done = 1; s.win = (s.enemies == 0); s.resp_left = 0;
        end else begin
            bit last = eh && (s.enemies == 1);
            bit shot = sh && (s.resp_left == 0) && !last;
            int old  = s.score;
            if (eh) begin
                s.enemies = s.enemies - 1;
                s.score   = (s.score + pt_p[k] > 9999) ? 9999 : s.score + pt_p[k];
            end
            if (shot) s.lives = s.lives - 1;
`ifdef BONUS_LIFE_EN
            if (eh && !s.bonus && old < 1000 && s.score >= 1000) begin
                s.bonus = 1;
                if (s.lives < 3) s.lives = s.lives + 1;
            end
`else
            if (old > s.score) s.score = old;
`endif
            if (s.resp_left > 0) s.resp_left = s.resp_left - 1;
            if (shot && s.lives > 0) s.resp_left = rc_p[k];
        end
        return s;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_out(string tag, exp_t e, exp_t a);
        chk({tag, ".done"},         32'(a.done),    32'(e.done));
        chk({tag, ".win"},          32'(a.win),     32'(e.win));
        chk({tag, ".invuln"},       32'(a.invuln),  32'(e.invuln));
        chk({tag, ".lives"},        32'(a.lives),   32'(e.lives));
        chk({tag, ".enemies_left"}, 32'(a.enemies), 32'(e.enemies));
        chk({tag, ".score"},        32'(a.score),   32'(e.score));
    endtask

    // One stimulus cycle: inputs change on the falling edge, expectation queued for the next compare point.
    task automatic cyc(bit r, bit st, bit pl, bit eh, bit sh);
        @(negedge Clk);
        ifa.gameover = m[0].done;
        ifb.gameover = m[1].done;
        m[0] = step(m[0], 0, r, st, pl, eh, sh);
        m[1] = step(m[1], 1, r, st, pl, eh, sh);
        if (!r && Reset) begin
            // Asynchronous clear is checked right away, then again at the next edge.
            qa.push_back(expect_of(m[0]));
            qb.push_back(expect_of(m[1]));
        end
        qa.push_back(expect_of(m[0]));
        qb.push_back(expect_of(m[1]));
        ifa.start = st; ifa.play = pl; ifa.enemy_hit = eh; ifa.ship_hit = sh;
        ifb.start = st; ifb.play = pl; ifb.enemy_hit = eh; ifb.ship_hit = sh;
        Reset = r;
    endtask

    // Monitor: compare outputs shortly after every clock edge and after reset assertion.
    initial begin
        forever begin
            @(posedge Clk or negedge Reset);
            #1;
            if (qa.size() > 0)
                check_out("A", qa.pop_front(),
                          exp_t'({ifa.done, ifa.win, ifa.invuln, ifa.lives, ifa.enemies_left, ifa.score}));
            if (qb.size() > 0)
                check_out("B", qb.pop_front(),
                          exp_t'({ifb.done, ifb.win, ifb.invuln, ifb.lives, ifb.enemies_left, ifb.score}));
        end
    end

    // Stimulus: directed games first, then randomised games.
    initial begin
        ifa.start = 0; ifa.play = 0; ifa.gameover = 0; ifa.enemy_hit = 0; ifa.ship_hit = 0;
        ifb.start = 0; ifb.play = 0; ifb.gameover = 0; ifb.enemy_hit = 0; ifb.ship_hit = 0;
        m[0] = step(m[0], 0, 0, 0, 0, 0, 0);
        m[1] = step(m[1], 1, 0, 0, 0, 0, 0);

        repeat (3) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // Clear the whole wave of A with spaced kills; B saturates its score.
        repeat (2) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, 1, 1, 0);
            cyc(1, 0, 1, 0, 0);
            cyc(1, 0, 1, 0, 0);
        end
        repeat (4) cyc(1, 0, 1, 1, 1);
        repeat (2) cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 1, 1);

        // Ship hits after each invulnerability window, plus one hit inside it.
        repeat (2) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 1);
        repeat (4) cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 1);
        repeat (20) cyc(1, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 1, 0, 1);
            repeat (20) cyc(1, 0, 1, 0, 0);
        end
        repeat (2) cyc(1, 0, 0, 0, 0);

        // Last enemy and ship hit in the same cycle.
        repeat (2) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        repeat (39) cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 1, 1);
        repeat (4) cyc(1, 0, 1, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0);

        // Reset asserted in the middle of a game.
        repeat (2) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        repeat (7) cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 0, 1);
        repeat (3) cyc(1, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0);

        // Randomised games, including aborts, idle hits and rare resets.
        for (int g = 0; g < 30; g++) begin
            int len, st_len, eh_pct, sh_pct;
            len    = $urandom_range(30, 400);
            st_len = $urandom_range(1, 3);
            eh_pct = $urandom_range(15, 60);
            sh_pct = $urandom_range(1, 10);
            repeat (st_len) cyc(1, 1, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            for (int c = 0; c < len; c++)
                cyc($urandom_range(0, 999) != 0, 0, 1,
                    $urandom_range(0, 99) < eh_pct, $urandom_range(0, 99) < sh_pct);
            repeat ($urandom_range(1, 4)) cyc(1, 0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        repeat (3) cyc(1, 0, 0, 0, 0);
        @(posedge Clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
